// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: shift mode encodings,
// per-stage control payload and mode decode helpers.
package shift_pkg;

  localparam int SH_MODE_W = 3;

  localparam logic [SH_MODE_W-1:0] SH_SLL = 3'b000;
  localparam logic [SH_MODE_W-1:0] SH_SRL = 3'b001;
  localparam logic [SH_MODE_W-1:0] SH_SRA = 3'b010;
  localparam logic [SH_MODE_W-1:0] SH_ROL = 3'b011;
  localparam logic [SH_MODE_W-1:0] SH_ROR = 3'b100;

  // Width-independent part of the stage payload; the top wraps it with data/shamt/tag.
  typedef struct packed {
    logic [SH_MODE_W-1:0] mode;
    logic                 fill;
    logic                 err;
  } sh_ctrl_t;

  function automatic logic sh_legal(input logic [SH_MODE_W-1:0] m);
    return (m <= SH_ROR);
  endfunction

  function automatic logic sh_left(input logic [SH_MODE_W-1:0] m);
    return (m == SH_SLL) || (m == SH_ROL);
  endfunction

  function automatic logic sh_rot(input logic [SH_MODE_W-1:0] m);
    return (m == SH_ROL) || (m == SH_ROR);
  endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational level of the log shifter: shifts or rotates by DIST
// when en is set, otherwise passes data through.
module shift_level #(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             left,
  input  logic             rot,
  input  logic             fill,
  output logic [WIDTH-1:0] res
);

  logic [DIST-1:0] in_lo;
  logic [DIST-1:0] in_hi;

  always_comb begin
    in_lo = rot ? data[WIDTH-1 -: DIST] : {DIST{fill}};
    in_hi = rot ? data[DIST-1:0]        : {DIST{fill}};
    res   = data;
    if (en) begin
      res = left ? {data[WIDTH-DIST-1:0], in_lo} : {in_hi, data[WIDTH-1:DIST]};
    end
  end

endmodule

// File: rtl/shift_unit.sv
// Pipelined barrel shifter with rotates, valid/ready flow control and an
// illegal-mode flag. Latency is STAGES cycles; a stall freezes the whole pipe.
module shift_unit
  import shift_pkg::*;
#(
  parameter  int WIDTH  = 32,
  localparam int SHW    = $clog2(WIDTH),
  parameter  int STAGES = 2,
  parameter  int TAGW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [SHW-1:0]       in_shamt,
  input  logic [SH_MODE_W-1:0] in_mode,
  input  logic [TAGW-1:0]      in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_r,
  output logic [TAGW-1:0]      out_tag,
  output logic                 out_err
);

  localparam int PER = (SHW + STAGES - 1) / STAGES;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   shamt;
    sh_ctrl_t         ctrl;
    logic [TAGW-1:0]  tag;
  } stage_t;

  logic   en;
  stage_t head;

  // Fill and illegal-mode squashing are resolved once, before the first level.
  always_comb begin
    head.data      = sh_legal(in_mode) ? in_a : '0;
    head.shamt     = in_shamt;
    head.ctrl.mode = in_mode;
    head.ctrl.fill = (in_mode == SH_SRA) & in_a[WIDTH-1];
    head.ctrl.err  = ~sh_legal(in_mode);
    head.tag       = in_tag;
  end

  // Global enable: out_ready -> in_ready is a combinational path.
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = s * PER;
    localparam int HI = (LO + PER < SHW) ? LO + PER : SHW;

    stage_t cur;
    stage_t nxt;
    stage_t q;
    logic   vin;
    logic   vld;

    if (s == 0) begin : g_head
      assign cur = head;
      assign vin = in_valid;
    end else begin : g_body
      assign cur = g_stage[s-1].q;
      assign vin = g_stage[s-1].vld;
    end

    if (LO < SHW) begin : g_shift
      always_comb begin
        nxt      = cur;
        nxt.data = g_lvl[HI-1].d_out;
      end
    end else begin : g_pass
      assign nxt = cur;
    end

    // ---- stage register boundary ----
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld <= 1'b0;
      end else if (en) begin
        vld <= vin;
      end
    end

    if (s == STAGES - 1) begin : g_last
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
        end else if (en) begin
          q <= nxt;
        end
      end
      logic unused_tail;
      assign unused_tail = ^{q.shamt, q.ctrl.mode, q.ctrl.fill};
    end else begin : g_mid
      always_ff @(posedge clk) begin
        if (en) begin
          q <= nxt;
        end
      end
    end
  end

  for (genvar i = 0; i < SHW; i++) begin : g_lvl
    localparam int ST = i / PER;

    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;

    if (i % PER == 0) begin : g_first
      assign d_in = g_stage[ST].cur.data;
    end else begin : g_chain
      assign d_in = g_lvl[i-1].d_out;
    end

    shift_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << i)
    ) u_level (
      .data (d_in),
      .en   (g_stage[ST].cur.shamt[i]),
      .left (sh_left(g_stage[ST].cur.ctrl.mode)),
      .rot  (sh_rot(g_stage[ST].cur.ctrl.mode)),
      .fill (g_stage[ST].cur.ctrl.fill),
      .res  (d_out)
    );
  end

  assign out_valid = g_stage[STAGES-1].vld;
  assign out_r     = g_stage[STAGES-1].q.data;
  assign out_tag   = g_stage[STAGES-1].q.tag;
  assign out_err   = g_stage[STAGES-1].vld & g_stage[STAGES-1].q.ctrl.err;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: three instances (32b/2 stages, 32b/1 stage,
// 64b/5 stages) exercising modes, latency, stalls, illegal modes and reset.
module tb_shift_unit;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_iv, a_ir, a_ov, a_or, a_err;
  logic [31:0] a_in, a_r;
  logic [4:0]  a_sh, a_tg, a_otg;
  logic [2:0]  a_md;

  logic        b_iv, b_ir, b_ov, b_or, b_err;
  logic [31:0] b_in, b_r;
  logic [4:0]  b_sh, b_tg, b_otg;
  logic [2:0]  b_md;

  logic        c_iv, c_ir, c_ov, c_or, c_err;
  logic [63:0] c_in, c_r;
  logic [5:0]  c_sh;
  logic [4:0]  c_tg, c_otg;
  logic [2:0]  c_md;

  shift_unit #(.WIDTH(32), .STAGES(2), .TAGW(5)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_a(a_in),
    .in_shamt(a_sh), .in_mode(a_md), .in_tag(a_tg), .out_valid(a_ov),
    .out_ready(a_or), .out_r(a_r), .out_tag(a_otg), .out_err(a_err));

  shift_unit #(.WIDTH(32), .STAGES(1), .TAGW(5)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_a(b_in),
    .in_shamt(b_sh), .in_mode(b_md), .in_tag(b_tg), .out_valid(b_ov),
    .out_ready(b_or), .out_r(b_r), .out_tag(b_otg), .out_err(b_err));

  shift_unit #(.WIDTH(64), .STAGES(5), .TAGW(5)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_a(c_in),
    .in_shamt(c_sh), .in_mode(c_md), .in_tag(c_tg), .out_valid(c_ov),
    .out_ready(c_or), .out_r(c_r), .out_tag(c_otg), .out_err(c_err));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] r_of(input int w);
    case (w)
      0:       return {32'd0, a_r};
      1:       return {32'd0, b_r};
      default: return c_r;
    endcase
  endfunction

  function automatic logic ov_of(input int w);
    case (w)
      0:       return a_ov;
      1:       return b_ov;
      default: return c_ov;
    endcase
  endfunction

  function automatic logic ir_of(input int w);
    case (w)
      0:       return a_ir;
      1:       return b_ir;
      default: return c_ir;
    endcase
  endfunction

  function automatic logic err_of(input int w);
    case (w)
      0:       return a_err;
      1:       return b_err;
      default: return c_err;
    endcase
  endfunction

  function automatic logic [4:0] tag_of(input int w);
    case (w)
      0:       return a_otg;
      1:       return b_otg;
      default: return c_otg;
    endcase
  endfunction

  // One isolated operation; checks exact latency and the result fields.
  task automatic op(input int w, input string nm, input logic [2:0] md, input logic [63:0] a,
                    input logic [5:0] sh, input logic [4:0] tg, input logic [63:0] exp,
                    input logic eerr);
    int lat;
    lat = (w == 0) ? 2 : (w == 1) ? 1 : 5;
    case (w)
      0:       begin a_iv = 1'b1; a_md = md; a_in = a[31:0]; a_sh = sh[4:0]; a_tg = tg; end
      1:       begin b_iv = 1'b1; b_md = md; b_in = a[31:0]; b_sh = sh[4:0]; b_tg = tg; end
      default: begin c_iv = 1'b1; c_md = md; c_in = a;       c_sh = sh;      c_tg = tg; end
    endcase
    #1;
    check({nm, "_rdy"}, ir_of(w), 1);
    @(posedge clk);
    #1;
    a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      check({nm, "_early"}, ov_of(w), 0);
      @(posedge clk);
    end
    @(negedge clk);
    check({nm, "_vld"}, ov_of(w), 1);
    check({nm, "_r"},   r_of(w), exp);
    check({nm, "_tag"}, tag_of(w), tg);
    check({nm, "_err"}, err_of(w), eerr);
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  st_md  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd4};
  logic [4:0]  st_sh  [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8};
  logic [31:0] st_exp [8] = '{32'h000000F0, 32'h00000078, 32'h0000003C, 32'h00000780,
                              32'h0000000F, 32'h00001E00, 32'h00000003, 32'hF0000000};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ni, no;
    logic [31:0] held_r;
    logic [4:0]  held_t;

    rst  = 1'b1;
    a_iv = 1'b0; a_or = 1'b1; a_in = '0; a_sh = '0; a_md = '0; a_tg = '0;
    b_iv = 1'b0; b_or = 1'b1; b_in = '0; b_sh = '0; b_md = '0; b_tg = '0;
    c_iv = 1'b0; c_or = 1'b1; c_in = '0; c_sh = '0; c_md = '0; c_tg = '0;

    repeat (2) @(negedge clk);
    check("rst_vld", a_ov, 0);
    check("rst_r",   a_r, 0);
    check("rst_tag", a_otg, 0);
    check("rst_err", a_err, 0);
    check("rst_c_r", c_r, 0);
    rst = 1'b0;
    #1;
    check("rst_rdy", a_ir, 1);

    op(0, "sra4",   SH_SRA, 64'h80000001, 6'd4,  5'h01, 64'hF8000000, 1'b0);
    op(0, "srl4",   SH_SRL, 64'h80000001, 6'd4,  5'h02, 64'h08000000, 1'b0);
    op(0, "sll31",  SH_SLL, 64'h00000003, 6'd31, 5'h03, 64'h80000000, 1'b0);
    for (int m = 0; m < 5; m++)
      op(0, "sh0",  3'(m),  64'h80000001, 6'd0,  5'(m), 64'h80000001, 1'b0);
    op(0, "ror8",   SH_ROR, 64'h12345678, 6'd8,  5'h04, 64'h78123456, 1'b0);
    op(0, "rol4",   SH_ROL, 64'h12345678, 6'd4,  5'h05, 64'h23456781, 1'b0);
    op(0, "rol31",  SH_ROL, 64'h00000001, 6'd31, 5'h06, 64'h80000000, 1'b0);
    op(0, "ror31",  SH_ROR, 64'h80000001, 6'd31, 5'h07, 64'h00000003, 1'b0);
    op(0, "srapos", SH_SRA, 64'h7FFFFFFF, 6'd31, 5'h08, 64'h00000000, 1'b0);
    op(0, "sraneg", SH_SRA, 64'h80000000, 6'd31, 5'h09, 64'hFFFFFFFF, 1'b0);
    op(0, "illeg",  3'b110, 64'hFFFFFFFF, 6'd3,  5'h1A, 64'h00000000, 1'b1);
    op(0, "postil", SH_SLL, 64'h00000001, 6'd1,  5'h0B, 64'h00000002, 1'b0);

    // Back-to-back stream with out_ready low in cycles 3..5.
    ni = 0; no = 0; held_r = '0; held_t = '0;
    @(negedge clk);
    for (int cyc = 0; cyc < 30 && no < 8; cyc++) begin
      a_or = !(cyc >= 3 && cyc <= 5);
      a_iv = (ni < 8);
      if (ni < 8) begin
        a_md = st_md[ni]; a_in = 32'h000000F0; a_sh = st_sh[ni]; a_tg = 5'(5'h10 + ni);
      end
      #1;
      if (cyc >= 3 && cyc <= 5) check("stall_rdy", a_ir, 0);
      if (cyc == 3) begin
        check("stall_vld", a_ov, 1);
        held_r = a_r;
        held_t = a_otg;
      end
      if (cyc >= 4 && cyc <= 6) begin
        check("hold_r",   a_r, held_r);
        check("hold_tag", a_otg, held_t);
      end
      if (a_ov && a_or) begin
        check("str_r",   a_r, st_exp[no]);
        check("str_tag", a_otg, 5'(5'h10 + no));
        no++;
      end
      if (a_iv && a_ir) ni++;
      @(posedge clk);
      @(negedge clk);
    end
    a_iv = 1'b0; a_or = 1'b1;
    check("str_out_cnt", no, 8);
    check("str_in_cnt",  ni, 8);
    repeat (3) begin
      #1 check("no_dup", a_ov, 0);
      @(negedge clk);
    end

    // Two ops in flight, then a sub-cycle asynchronous reset pulse.
    a_iv = 1'b1; a_md = SH_SLL; a_in = 32'h1; a_sh = 5'd1; a_tg = 5'h0C;
    @(posedge clk); #1;
    a_tg = 5'h0D;
    @(posedge clk); #1;
    a_iv = 1'b0;
    check("inflight_vld", a_ov, 1);
    #2 rst = 1'b1;
    #1 check("arst_vld", a_ov, 0);
    check("arst_r", a_r, 0);
    #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_vld", a_ov, 0);
    end
    check("post_rst_rdy", a_ir, 1);
    @(posedge clk); #1;

    op(1, "b_sra4",  SH_SRA, 64'h80000001, 6'd4, 5'h11, 64'hF8000000, 1'b0);
    op(1, "b_ror8",  SH_ROR, 64'h12345678, 6'd8, 5'h12, 64'h78123456, 1'b0);
    op(2, "c_sra4",  SH_SRA, 64'h8000000000000001, 6'd4,  5'h13, 64'hF800000000000000, 1'b0);
    op(2, "c_rol63", SH_ROL, 64'h0000000000000001, 6'd63, 5'h14, 64'h8000000000000000, 1'b0);
    op(2, "c_srl63", SH_SRL, 64'h8000000000000000, 6'd63, 5'h15, 64'h0000000000000001, 1'b0);
    op(2, "c_ror4",  SH_ROR, 64'h0123456789ABCDEF, 6'd4,  5'h16, 64'hF0123456789ABCDE, 1'b0);
    op(2, "c_illeg", 3'b111, 64'hFFFFFFFFFFFFFFFF, 6'd1,  5'h17, 64'h0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
